mem_arbiter: RTL
================

# mem_arbiter

Single-port memory access controller. It arbitrates between instruction fetch and the load/store path for the unified instruction/data memory and sequences each access through a fixed-latency read/write cycle. For the load/store path it also generates byte enables, performs sub-word alignment and sign extension, and flags misaligned or illegal accesses. It sits between the pipeline front-end/LSU and the memory macro.

## Interface
- `MEM_LATENCY`, default 1: cycles from `mem_en` to valid `mem_rdata`; range 1–7.
- `clk` in 1: system clock; all state changes on its rising edge.
- `reset` in 1: asynchronous, active-low reset.
- `if_req` in 1: fetch request; held until `if_gnt`.
- `if_addr` in 32: fetch byte address (bits [1:0] ignored).
- `if_gnt` out 1: fetch request accepted this cycle.
- `if_rvalid` out 1: one-cycle pulse; `if_rdata` valid.
- `if_rdata` out 32: fetched instruction word.
- `ls_req` in 1: load/store request; held until `ls_gnt`.
- `ls_we` in 1: 1 = store, 0 = load.
- `ls_funct3` in 3: RV32I size/sign code.
- `ls_addr` in 32: byte address.
- `ls_wdata` in 32: store data, right-aligned.
- `ls_gnt` out 1: load/store request accepted this cycle.
- `ls_rvalid` out 1: one-cycle completion pulse for loads and stores.
- `ls_rdata` out 32: aligned, extended load data; 0 for stores and errors.
- `ls_err` out 1: qualifies `ls_rvalid`; misaligned or illegal funct3.
- `mem_en` out 1: memory access strobe.
- `mem_we` out 1: write strobe.
- `mem_be` out 4: byte enables.
- `mem_addr` out 32: word address, {addr[31:2], 2'b00}.
- `mem_wdata` out 32: lane-replicated store data.
- `mem_rdata` in 32: memory read word.

## Operation
- FSM states:
  - IDLE: accepts a request.
  - BUSY: counts memory latency.
  - RESP: pulses rvalid.
  - ERR: pulses rvalid with `ls_err`.
- Exactly one access is outstanding at a time.
- Arbitration in IDLE:
  - One requester: that requester wins.
  - Both requesting: the requester not granted last wins. `last_ls` resets to 0, so LS wins first contention.
  - Grant (`gnt` = 1) is combinational in IDLE, in the cycle of acceptance.
  - All request fields are latched at grant.
- Legal granted access:
  - `mem_en` = 1 in the grant cycle.
  - `mem_we`/`mem_be`/`mem_addr`/`mem_wdata` are driven combinationally from the request.
  - Next state is BUSY; the counter loads `MEM_LATENCY`-1.
- BUSY decrements the counter; at 0 it moves to RESP.
- RESP:
  - Captures `mem_rdata`, drives the requester's rvalid for 1 cycle, then returns to IDLE.
  - No grant is issued in RESP.
- LS decoding:
  - funct3 000 SB/LB: be = 4'b0001 << addr[1:0]; wdata = {4{wdata[7:0]}}; load = sign-extended byte lane.
  - funct3 001 SH/LH: addr[0] must be 0; be = addr[1] ? 4'b1100 : 4'b0011; wdata = {2{wdata[15:0]}}; load = sign-extended half.
  - funct3 010 SW/LW: addr[1:0] must be 0; be = 4'b1111.
  - funct3 100 LBU and 101 LHU: as LB/LH with zero extension. Legal for loads only.
  - Any other code, a store with 1xx, or a misaligned address is an error.
- Error access:
  - Granted normally; `mem_en` stays 0.
  - Next state is ERR: `ls_rvalid` = 1, `ls_err` = 1, `ls_rdata` = 0 for one cycle, then IDLE.
- Fetch reads: `mem_be` = 4'b1111; `if_rdata` = `mem_rdata`.
- Outputs when not active:
  - `mem_*` = 0 whenever `mem_en` = 0.
  - `rvalid`/`rdata`/`err` = 0 outside RESP/ERR.

## Timing
- Reset (asynchronous assert, synchronous deassert externally):
  - State goes to IDLE; counter = 0; `last_ls` = 0.
  - All outputs 0, including gnt, rvalid, rdata, err, and `mem_*`.
  - An in-flight access is dropped with no rvalid. A memory write already strobed is not undone.
- Latency:
  - Grant at cycle T.
  - rvalid at T+`MEM_LATENCY`+1.
  - Next grant no earlier than T+`MEM_LATENCY`+2.
  - Error responses arrive at T+1.
- Handshake: a requester lowering req before gnt is legal; nothing is issued.
- Requests arriving during BUSY/RESP wait; no request is lost.

## Structure
- Package `mem_pkg` holds:
  - `funct3_e` (LB=0, LH=1, LW=2, LBU=4, LHU=5);
  - `state_e` (IDLE, BUSY, RESP, ERR);
  - `WORD_W`=32, `BE_W`=4.
- Sub-module `mem_lsu_align` (combinational) owns all sub-word logic. From funct3, addr[1:0], wdata and rdata it produces be, wdata, extended rdata, and err.
- Arbiter/FSM is in `mem_arbiter`; memory arrays stay external.

## Test plan
- Reset mid-BUSY: `if_req` granted, `reset`=0 one cycle later → all outputs 0, no `if_rvalid`; after release, IDLE and `last_ls`=0.
- Fetch, `MEM_LATENCY`=2: `if_addr`=0x0000_0106, `mem_rdata`=0x0010_0093 → `mem_addr`=0x104, `mem_be`=4'hF, `if_rvalid` at T+3 with 0x0010_0093.
- Contention: `if_req` and `ls_req` held together for 4 accesses → grants alternate LS, IF, LS, IF; one access per `MEM_LATENCY`+2 cycles.
- SB: `ls_addr`=0x203, `ls_wdata`=0xAABB_CC80, funct3=000 → `mem_be`=4'b1000, `mem_wdata`=0x8080_8080, `mem_addr`=0x200; `ls_rvalid` with `ls_rdata`=0.
- LB vs LBU: addr 0x201, `mem_rdata`=0x1234_F0FF → LB `ls_rdata`=0xFFFF_FFF0; LBU `ls_rdata`=0x0000_00F0.
- Errors:
  - LW at 0x202 → `ls_rvalid`=`ls_err`=1 at T+1, `mem_en` never 1.
  - Store with funct3=100 → same error response.

Source files
------------

// File: rtl/mem_pkg.sv
// Shared types and widths for the unified instruction/data memory controller.
package mem_pkg;
  localparam int WORD_W = 32;
  localparam int BE_W   = 4;

  typedef enum logic [2:0] {
    LB  = 3'd0,
    LH  = 3'd1,
    LW  = 3'd2,
    LBU = 3'd4,
    LHU = 3'd5
  } funct3_e;

  typedef enum logic [1:0] {
    IDLE,
    BUSY,
    RESP,
    ERR
  } state_e;
endpackage

// File: rtl/mem_lsu_align.sv
// Sub-word handling for the load/store path: byte enables, store lane replication,
// load lane extraction with sign/zero extension, and legality check. Purely combinational.
module mem_lsu_align
  import mem_pkg::*;
(
  input  logic [2:0]        funct3,
  input  logic              we,
  input  logic [1:0]        addr_lo,
  input  logic [WORD_W-1:0] wdata_i,
  input  logic [WORD_W-1:0] rdata_i,
  output logic [BE_W-1:0]   be,
  output logic [WORD_W-1:0] wdata_o,
  output logic [WORD_W-1:0] rdata_o,
  output logic              err
);
  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  always_comb begin
    byte_sel = rdata_i[{addr_lo, 3'b000} +: 8];
    half_sel = addr_lo[1] ? rdata_i[31:16] : rdata_i[15:0];
    be       = '0;
    wdata_o  = '0;
    rdata_o  = '0;
    err      = 1'b0;
    case (funct3)
      LB, LBU: begin
        be      = 4'b0001 << addr_lo;
        wdata_o = {4{wdata_i[7:0]}};
        rdata_o = {{24{byte_sel[7] & (funct3 == LB)}}, byte_sel};
        err     = we && (funct3 == LBU);
      end
      LH, LHU: begin
        be      = addr_lo[1] ? 4'b1100 : 4'b0011;
        wdata_o = {2{wdata_i[15:0]}};
        rdata_o = {{16{half_sel[15] & (funct3 == LH)}}, half_sel};
        err     = addr_lo[0] || (we && (funct3 == LHU));
      end
      LW: begin
        be      = 4'b1111;
        wdata_o = wdata_i;
        rdata_o = rdata_i;
        err     = (addr_lo != 2'b00);
      end
      default: err = 1'b1;
    endcase
  end
endmodule

// File: rtl/mem_arbiter.sv
// Single-port memory controller: round-robin fetch vs load/store, one access in flight,
// response MEM_LATENCY+1 cycles after grant (errors next cycle); requests wait while busy.
module mem_arbiter
  import mem_pkg::*;
#(
  parameter int unsigned MEM_LATENCY = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              if_req,
  input  logic [WORD_W-1:0] if_addr,
  output logic              if_gnt,
  output logic              if_rvalid,
  output logic [WORD_W-1:0] if_rdata,
  input  logic              ls_req,
  input  logic              ls_we,
  input  logic [2:0]        ls_funct3,
  input  logic [WORD_W-1:0] ls_addr,
  input  logic [WORD_W-1:0] ls_wdata,
  output logic              ls_gnt,
  output logic              ls_rvalid,
  output logic [WORD_W-1:0] ls_rdata,
  output logic              ls_err,
  output logic              mem_en,
  output logic              mem_we,
  output logic [BE_W-1:0]   mem_be,
  output logic [WORD_W-1:0] mem_addr,
  output logic [WORD_W-1:0] mem_wdata,
  input  logic [WORD_W-1:0] mem_rdata
);
  state_e            state_q, state_d;
  logic [2:0]        cnt_q, cnt_d;
  logic              last_ls_q, last_ls_d;
  logic              is_ls_q, is_ls_d;
  logic              we_q, we_d;
  logic [2:0]        funct3_q, funct3_d;
  logic [1:0]        addr_lo_q, addr_lo_d;
  logic [WORD_W-1:0] rdata_q, rdata_d;

  logic              idle, pick_ls, take, bad;
  logic [WORD_W-1:0] sel_addr;
  logic [2:0]        al_funct3;
  logic              al_we;
  logic [1:0]        al_lo;
  logic [BE_W-1:0]   al_be;
  logic [WORD_W-1:0] al_wdata, al_rdata;
  logic              al_err;

  // The aligner sees the live request while idle and the latched one while responding.
  always_comb begin
    idle      = (state_q == IDLE) && reset;
    pick_ls   = ls_req && (!if_req || !last_ls_q);
    take      = idle && (if_req || ls_req);
    sel_addr  = pick_ls ? ls_addr : if_addr;
    al_funct3 = (state_q == IDLE) ? ls_funct3 : funct3_q;
    al_we     = (state_q == IDLE) ? ls_we : we_q;
    al_lo     = (state_q == IDLE) ? sel_addr[1:0] : addr_lo_q;
    bad       = pick_ls && al_err;
  end

  mem_lsu_align u_align (
    .funct3  (al_funct3),
    .we      (al_we),
    .addr_lo (al_lo),
    .wdata_i (ls_wdata),
    .rdata_i (rdata_q),
    .be      (al_be),
    .wdata_o (al_wdata),
    .rdata_o (al_rdata),
    .err     (al_err)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      last_ls_q <= 1'b0;
      is_ls_q   <= 1'b0;
      we_q      <= 1'b0;
      funct3_q  <= '0;
      addr_lo_q <= '0;
      rdata_q   <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      last_ls_q <= last_ls_d;
      is_ls_q   <= is_ls_d;
      we_q      <= we_d;
      funct3_q  <= funct3_d;
      addr_lo_q <= addr_lo_d;
      rdata_q   <= rdata_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    last_ls_d = last_ls_q;
    is_ls_d   = is_ls_q;
    we_d      = we_q;
    funct3_d  = funct3_q;
    addr_lo_d = addr_lo_q;
    rdata_d   = rdata_q;
    case (state_q)
      IDLE: begin
        if (take) begin
          last_ls_d = pick_ls;
          is_ls_d   = pick_ls;
          we_d      = pick_ls && ls_we;
          funct3_d  = ls_funct3;
          addr_lo_d = sel_addr[1:0];
          if (bad) begin
            state_d = ERR;
          end else begin
            state_d = BUSY;
            cnt_d   = 3'(MEM_LATENCY - 1);
          end
        end
      end
      BUSY: begin
        if (cnt_q == 3'd0) begin
          rdata_d = mem_rdata;
          state_d = RESP;
        end else begin
          cnt_d = cnt_q - 3'd1;
        end
      end
      RESP:    state_d = IDLE;
      ERR:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    if_gnt    = 1'b0;
    ls_gnt    = 1'b0;
    if_rvalid = 1'b0;
    if_rdata  = '0;
    ls_rvalid = 1'b0;
    ls_rdata  = '0;
    ls_err    = 1'b0;
    mem_en    = 1'b0;
    mem_we    = 1'b0;
    mem_be    = '0;
    mem_addr  = '0;
    mem_wdata = '0;
    if (take) begin
      ls_gnt = pick_ls;
      if_gnt = !pick_ls;
      if (!bad) begin
        mem_en   = 1'b1;
        mem_addr = {sel_addr[WORD_W-1:2], 2'b00};
        if (pick_ls) begin
          mem_we    = ls_we;
          mem_be    = al_be;
          mem_wdata = ls_we ? al_wdata : '0;
        end else begin
          mem_be = '1;
        end
      end
    end
    if (state_q == RESP) begin
      if (is_ls_q) begin
        ls_rvalid = 1'b1;
        ls_rdata  = we_q ? '0 : al_rdata;
      end else begin
        if_rvalid = 1'b1;
        if_rdata  = rdata_q;
      end
    end
    if (state_q == ERR) begin
      ls_rvalid = 1'b1;
      ls_err    = 1'b1;
    end
  end
endmodule
